// File: rtl/dcache_pkg.sv
// Shared types and helpers for the DRAM-cache request path.
// The struct and the helper function use the default geometry
// (64 B lines, 1024 sets, 16 slaves).
package dcache_pkg;

  localparam int DEF_OFFSET_W = 6;
  localparam int DEF_INDEX_W  = 10;
  localparam int DEF_SLV_W    = 4;
  localparam int DEF_ID_W     = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_ENTRY_W  = 128;
  localparam int DEF_PAD_W    = DEF_ENTRY_W -
                                (1 + DEF_SLV_W + DEF_INDEX_W + DEF_ID_W + DEF_ADDR_W);

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_type_e;

  // Packed FIFO entry.  The last field listed is the least significant one,
  // so the address sits at bit 0 and the padding at the top.
  typedef struct packed {
    logic [DEF_PAD_W-1:0]   pad;
    logic                   is_write;
    logic [DEF_SLV_W-1:0]   slave;
    logic [DEF_INDEX_W-1:0] idx;
    logic [DEF_ID_W-1:0]    id;
    logic [DEF_ADDR_W-1:0]  addr;
  } req_entry_t;

  // Set index for the default geometry, optionally folded with the low tag bits.
  function automatic logic [DEF_INDEX_W-1:0] calc_index(
    input logic [DEF_ADDR_W-1:0] addr,
    input logic                  hash_en
  );
    logic [DEF_INDEX_W-1:0] idx;
    logic [DEF_INDEX_W-1:0] tag;
    idx = addr[DEF_OFFSET_W +: DEF_INDEX_W];
    tag = DEF_INDEX_W'(addr >> (DEF_OFFSET_W + DEF_INDEX_W));
    if (hash_en) begin
      idx = idx ^ tag;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.  On a tie, the requester that did not
// win last time is granted.  The history only advances when the caller
// signals that the grant was actually taken.
module rr_arbiter2
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_reqRd,
  input  logic i_reqWr,
  input  logic i_update,
  output logic o_grantRd,
  output logic o_grantWr
);

  req_type_e r_last;

  // Grants are purely combinational from the requests and the last winner.
  assign o_grantRd = i_reqRd && (!i_reqWr || (r_last == REQ_WR));
  assign o_grantWr = i_reqWr && (!i_reqRd || (r_last == REQ_RD));

  // Remember the winner of every accepted grant; a write history out of reset
  // makes reads win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= REQ_WR;
    end else if (i_update) begin
      r_last <= o_grantWr ? REQ_WR : REQ_RD;
    end
  end

endmodule

// File: rtl/axi_index_dispatcher.sv
// Accepts AXI AR/AW requests, arbitrates them round-robin, derives the
// cache set index and target slave, and pushes one packed entry per request
// into the downstream request FIFO through a single output register.
module axi_index_dispatcher
  import dcache_pkg::*;
#(
  parameter int ID_W     = 32,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 10,
  parameter int SLV_W    = 4,
  parameter int ENTRY_W  = 128,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    arid_i,
  input  logic [ADDR_W-1:0]  araddr_i,
  input  logic               arvalid_i,
  output logic               arready_o,
  input  logic [ID_W-1:0]    awid_i,
  input  logic [ADDR_W-1:0]  awaddr_i,
  input  logic               awvalid_i,
  output logic               awready_o,
  input  logic               hash_en_i,
  input  logic               fifo_afull_i,
  output logic               fifo_write_enable_o,
  output logic [ENTRY_W-1:0] fifo_data_o,
  output logic [SLV_W-1:0]   slave_o,
  output logic [CNT_W-1:0]   rd_cnt_o,
  output logic [CNT_W-1:0]   wr_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int               TAG_SHIFT = OFFSET_W + INDEX_W;
  localparam int               PACK_W    = 1 + SLV_W + INDEX_W + ID_W + ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  generate
    if (ENTRY_W < PACK_W) begin : g_entryTooNarrow
      $error("axi_index_dispatcher: ENTRY_W is too narrow for the packed entry");
    end
    if (SLV_W > INDEX_W) begin : g_slaveTooWide
      $error("axi_index_dispatcher: SLV_W must not exceed INDEX_W");
    end
  endgenerate

  logic               w_grantRd;
  logic               w_grantWr;
  logic               w_push;
  logic               w_canAccept;
  logic               w_handshake;
  req_type_e          w_reqType;
  logic [ADDR_W-1:0]  w_selAddr;
  logic [ID_W-1:0]    w_selId;
  logic [INDEX_W-1:0] w_tag;
  logic [INDEX_W-1:0] w_idx;
  logic [SLV_W-1:0]   w_slave;

  logic               r_outValid;
  logic [ENTRY_W-1:0] r_entry;
  logic [SLV_W-1:0]   r_slave;
  logic [CNT_W-1:0]   r_rdCnt;
  logic [CNT_W-1:0]   r_wrCnt;
  logic [CNT_W-1:0]   r_stallCnt;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_reqRd   (arvalid_i),
    .i_reqWr   (awvalid_i),
    .i_update  (w_handshake),
    .o_grantRd (w_grantRd),
    .o_grantWr (w_grantWr)
  );

  // The held entry drains whenever the FIFO has room; a draining register
  // can take a new request in the same cycle, giving one request per cycle.
  assign w_push      = r_outValid && !fifo_afull_i;
  assign w_canAccept = !r_outValid || w_push;
  assign arready_o   = w_canAccept && w_grantRd;
  assign awready_o   = w_canAccept && w_grantWr;
  assign w_handshake = arready_o || awready_o;

  // Pick the granted channel's payload and derive index and slave from it.
  // The tag is whatever lies above offset+index, truncated or zero-extended
  // to the index width before folding.
  assign w_reqType = w_grantWr ? REQ_WR : REQ_RD;
  assign w_selAddr = (w_reqType == REQ_WR) ? awaddr_i : araddr_i;
  assign w_selId   = (w_reqType == REQ_WR) ? awid_i : arid_i;
  assign w_tag     = INDEX_W'(w_selAddr >> TAG_SHIFT);
  assign w_idx     = w_selAddr[OFFSET_W +: INDEX_W] ^ (hash_en_i ? w_tag : '0);
  assign w_slave   = w_idx[SLV_W-1:0];

  assign fifo_write_enable_o = w_push;
  assign fifo_data_o         = r_entry;
  assign slave_o             = r_slave;
  assign rd_cnt_o            = r_rdCnt;
  assign wr_cnt_o            = r_wrCnt;
  assign stall_cnt_o         = r_stallCnt;

  // Output register: load on handshake, empty on a push that has no
  // replacement.  The payload keeps its last value while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_entry    <= '0;
      r_slave    <= '0;
    end else if (w_handshake) begin
      r_outValid <= 1'b1;
      r_entry    <= ENTRY_W'({w_grantWr, w_slave, w_idx, w_selId, w_selAddr});
      r_slave    <= w_slave;
    end else if (w_push) begin
      r_outValid <= 1'b0;
    end
  end

  // Saturating statistics: accepted reads, accepted writes, and cycles in
  // which a held entry was blocked by the almost-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdCnt    <= '0;
      r_wrCnt    <= '0;
      r_stallCnt <= '0;
    end else begin
      if (arready_o && (r_rdCnt != CNT_MAX)) begin
        r_rdCnt <= r_rdCnt + CNT_W'(1);
      end
      if (awready_o && (r_wrCnt != CNT_MAX)) begin
        r_wrCnt <= r_wrCnt + CNT_W'(1);
      end
      if (r_outValid && fifo_afull_i && (r_stallCnt != CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_index_dispatcher.sv
// Self-checking bench for axi_index_dispatcher (default geometry, 4-bit
// counters so saturation is reachable).  Directed scenarios first, then a
// randomized run against a transaction-level reference model.
module tb_axi_index_dispatcher;

  localparam int ID_W     = 32;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 10;
  localparam int SLV_W    = 4;
  localparam int ENTRY_W  = 128;
  localparam int CNT_W    = 4;
  localparam int CNT_TOP  = 15;

  logic               clk;
  logic               rst_n;
  logic [ID_W-1:0]    arid_i;
  logic [ADDR_W-1:0]  araddr_i;
  logic               arvalid_i;
  logic               arready_o;
  logic [ID_W-1:0]    awid_i;
  logic [ADDR_W-1:0]  awaddr_i;
  logic               awvalid_i;
  logic               awready_o;
  logic               hash_en_i;
  logic               fifo_afull_i;
  logic               fifo_write_enable_o;
  logic [ENTRY_W-1:0] fifo_data_o;
  logic [SLV_W-1:0]   slave_o;
  logic [CNT_W-1:0]   rd_cnt_o;
  logic [CNT_W-1:0]   wr_cnt_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  int nTests = 0;
  int nFail  = 0;

  axi_index_dispatcher #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W),
    .SLV_W(SLV_W), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .arid_i              (arid_i),
    .araddr_i            (araddr_i),
    .arvalid_i           (arvalid_i),
    .arready_o           (arready_o),
    .awid_i              (awid_i),
    .awaddr_i            (awaddr_i),
    .awvalid_i           (awvalid_i),
    .awready_o           (awready_o),
    .hash_en_i           (hash_en_i),
    .fifo_afull_i        (fifo_afull_i),
    .fifo_write_enable_o (fifo_write_enable_o),
    .fifo_data_o         (fifo_data_o),
    .slave_o             (slave_o),
    .rd_cnt_o            (rd_cnt_o),
    .wr_cnt_o            (wr_cnt_o),
    .stall_cnt_o         (stall_cnt_o)
  );

  // Free-running 10-unit clock; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected entry from the address arithmetic: 64-byte lines, 1024 sets,
  // tag is everything from bit 16 upward, slave is the index modulo 16.
  function automatic logic [127:0] modelEntry(input logic [31:0] addr,
                                              input logic [31:0] id,
                                              input bit isWr, input bit hash);
    int unsigned idx;
    int unsigned tag;
    idx = (addr / 64) % 1024;
    tag = addr / 65536;
    if (hash) idx = idx ^ (tag % 1024);
    return {49'b0, isWr, 4'(idx % 16), 10'(idx), id, addr};
  endfunction

  task automatic applyStimulus(input bit arV, input logic [31:0] arA, input logic [31:0] arI,
                               input bit awV, input logic [31:0] awA, input logic [31:0] awI,
                               input bit hash, input bit afull);
    arvalid_i    = arV;
    araddr_i     = arA;
    arid_i       = arI;
    awvalid_i    = awV;
    awaddr_i     = awA;
    awid_i       = awI;
    hash_en_i    = hash;
    fifo_afull_i = afull;
  endtask

  task automatic doReset();
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1, 32'h40, 5, 1, 32'h80, 6, 0, 0);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_push got %0h want 0", fifo_write_enable_o); end
    nTests++; if (fifo_data_o !== '0) begin nFail++; $display("[TB] FAIL reset_data got %0h want 0", fifo_data_o); end
    nTests++; if (slave_o !== '0) begin nFail++; $display("[TB] FAIL reset_slave got %0h want 0", slave_o); end
    nTests++; if ({rd_cnt_o, wr_cnt_o, stall_cnt_o} !== '0) begin nFail++; $display("[TB] FAIL reset_counters got %0h want 0", {rd_cnt_o, wr_cnt_o, stall_cnt_o}); end
    nTests++; if (arready_o !== 1'b1) begin nFail++; $display("[TB] FAIL reset_arready got %0h want 1", arready_o); end
    nTests++; if (awready_o !== 1'b0) begin nFail++; $display("[TB] FAIL reset_awready got %0h want 0", awready_o); end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    doReset();
    applyStimulus(1, 32'h0000_1A40, 3, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (arready_o !== 1'b1) begin nFail++; $display("[TB] FAIL read_arready got %0h want 1", arready_o); end
    nTests++; if (awready_o !== 1'b0) begin nFail++; $display("[TB] FAIL read_awready got %0h want 0", awready_o); end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL read_push got %0h want 1", fifo_write_enable_o); end
    nTests++; if (slave_o !== 4'h9) begin nFail++; $display("[TB] FAIL read_slave got %0h want 9", slave_o); end
    nTests++; if (fifo_data_o[73:64] !== 10'h069) begin nFail++; $display("[TB] FAIL read_idx got %0h want 69", fifo_data_o[73:64]); end
    nTests++; if (fifo_data_o[78] !== 1'b0) begin nFail++; $display("[TB] FAIL read_iswrite got %0h want 0", fifo_data_o[78]); end
    nTests++; if (fifo_data_o[63:32] !== 32'd3) begin nFail++; $display("[TB] FAIL read_id got %0h want 3", fifo_data_o[63:32]); end
    nTests++; if (fifo_data_o !== modelEntry(32'h1A40, 3, 0, 0)) begin nFail++; $display("[TB] FAIL read_entry got %0h want %0h", fifo_data_o, modelEntry(32'h1A40, 3, 0, 0)); end
    nTests++; if (rd_cnt_o !== 4'd1) begin nFail++; $display("[TB] FAIL read_rdcnt got %0d want 1", rd_cnt_o); end
  endtask

  task automatic test_hash();
    doReset();
    applyStimulus(0, 0, 0, 1, 32'h0003_1A40, 7, 1, 0);
    #2;
    nTests++; if (awready_o !== 1'b1) begin nFail++; $display("[TB] FAIL hash_awready got %0h want 1", awready_o); end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL hash_push got %0h want 1", fifo_write_enable_o); end
    nTests++; if (fifo_data_o[73:64] !== 10'h06A) begin nFail++; $display("[TB] FAIL hash_idx got %0h want 6a", fifo_data_o[73:64]); end
    nTests++; if (slave_o !== 4'hA) begin nFail++; $display("[TB] FAIL hash_slave got %0h want a", slave_o); end
    nTests++; if (fifo_data_o[78] !== 1'b1) begin nFail++; $display("[TB] FAIL hash_iswrite got %0h want 1", fifo_data_o[78]); end
    nTests++; if (wr_cnt_o !== 4'd1) begin nFail++; $display("[TB] FAIL hash_wrcnt got %0d want 1", wr_cnt_o); end
    nTests++; if (rd_cnt_o !== 4'd0) begin nFail++; $display("[TB] FAIL hash_rdcnt got %0d want 0", rd_cnt_o); end
  endtask

  task automatic test_back_to_back();
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 32'h0000_2000 + 32'(k * 64), 32'(k), 1, 32'h0000_4000 + 32'(k * 64), 32'(k + 8), 0, 0);
      #2;
      nTests++; if (arready_o !== (k % 2 == 0)) begin nFail++; $display("[TB] FAIL b2b_arready[%0d] got %0h want %0h", k, arready_o, (k % 2 == 0)); end
      nTests++; if (awready_o !== (k % 2 == 1)) begin nFail++; $display("[TB] FAIL b2b_awready[%0d] got %0h want %0h", k, awready_o, (k % 2 == 1)); end
      if (k > 0) begin
        nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_push[%0d] got %0h want 1", k, fifo_write_enable_o); end
        nTests++; if (fifo_data_o[78] !== (k % 2 == 0)) begin nFail++; $display("[TB] FAIL b2b_iswrite[%0d] got %0h want %0h", k, fifo_data_o[78], (k % 2 == 0)); end
      end
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_lastpush got %0h want 1", fifo_write_enable_o); end
    nTests++; if (fifo_data_o !== modelEntry(32'h40C0, 11, 1, 0)) begin nFail++; $display("[TB] FAIL b2b_lastentry got %0h want %0h", fifo_data_o, modelEntry(32'h40C0, 11, 1, 0)); end
  endtask

  task automatic test_backpressure();
    doReset();
    applyStimulus(1, 32'h0000_5A40, 9, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (arready_o !== 1'b1) begin nFail++; $display("[TB] FAIL bp_accept got %0h want 1", arready_o); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, 32'h0007_0040, 11, 0, 1);
      #2;
      nTests++; if (fifo_write_enable_o !== 1'b0) begin nFail++; $display("[TB] FAIL bp_push[%0d] got %0h want 0", k, fifo_write_enable_o); end
      nTests++; if ({arready_o, awready_o} !== 2'b00) begin nFail++; $display("[TB] FAIL bp_readies[%0d] got %0h want 0", k, {arready_o, awready_o}); end
      nTests++; if (fifo_data_o !== modelEntry(32'h5A40, 9, 0, 0)) begin nFail++; $display("[TB] FAIL bp_hold[%0d] got %0h want %0h", k, fifo_data_o, modelEntry(32'h5A40, 9, 0, 0)); end
    end
    @(negedge clk);
    applyStimulus(0, 0, 0, 1, 32'h0007_0040, 11, 0, 0);
    #2;
    nTests++; if (stall_cnt_o !== 4'd5) begin nFail++; $display("[TB] FAIL bp_stallcnt got %0d want 5", stall_cnt_o); end
    nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL bp_release_push got %0h want 1", fifo_write_enable_o); end
    nTests++; if (awready_o !== 1'b1) begin nFail++; $display("[TB] FAIL bp_release_awready got %0h want 1", awready_o); end
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b1) begin nFail++; $display("[TB] FAIL bp_next_push got %0h want 1", fifo_write_enable_o); end
    nTests++; if (fifo_data_o !== modelEntry(32'h0007_0040, 11, 1, 0)) begin nFail++; $display("[TB] FAIL bp_next_entry got %0h want %0h", fifo_data_o, modelEntry(32'h0007_0040, 11, 1, 0)); end
    nTests++; if (stall_cnt_o !== 4'd5) begin nFail++; $display("[TB] FAIL bp_stall_after got %0d want 5", stall_cnt_o); end
  endtask

  task automatic test_reset_midop();
    doReset();
    applyStimulus(1, 32'h0000_1A40, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    nTests++; if (fifo_write_enable_o !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_held got %0h want 0", fifo_write_enable_o); end
    @(negedge clk);
    #2;
    rst_n        = 1'b0;
    fifo_afull_i = 1'b0;
    #1;
    nTests++; if (fifo_write_enable_o !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_push got %0h want 0", fifo_write_enable_o); end
    nTests++; if ({rd_cnt_o, stall_cnt_o} !== '0) begin nFail++; $display("[TB] FAIL midrst_counters got %0h want 0", {rd_cnt_o, stall_cnt_o}); end
    nTests++; if (fifo_data_o !== '0) begin nFail++; $display("[TB] FAIL midrst_data got %0h want 0", fifo_data_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      nTests++; if (fifo_write_enable_o !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_after[%0d] got %0h want 0", k, fifo_write_enable_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    doReset();
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1, $urandom, 32'(k), 0, 0, 0, 0, 0);
      #2;
      nTests++; if (arready_o !== 1'b1) begin nFail++; $display("[TB] FAIL sat_accept[%0d] got %0h want 1", k, arready_o); end
      @(negedge clk);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    nTests++; if (rd_cnt_o !== 4'd15) begin nFail++; $display("[TB] FAIL sat_rdcnt got %0d want 15", rd_cnt_o); end
    nTests++; if (wr_cnt_o !== 4'd0) begin nFail++; $display("[TB] FAIL sat_wrcnt got %0d want 0", wr_cnt_o); end
  endtask

  // Randomized traffic against a transaction-level model: one held slot,
  // a "who won last" flag, and saturating tallies.  Masters keep a request
  // and its payload stable until it is accepted.
  task automatic test_random();
    bit          mHeld = 0;
    bit          mLastWr = 1;
    logic [127:0] mEntry = '0;
    int          mRd = 0, mWr = 0, mSt = 0;
    bit          arV = 0, awV = 0, arTaken = 0, awTaken = 0;
    logic [31:0] arA = 0, arI = 0, awA = 0, awI = 0;
    bit          hash, afull, expPush, canAcc, expAr, expAw;
    doReset();
    for (int c = 0; c < 600; c++) begin
      if (!arV || arTaken) begin
        arV = ($urandom_range(0, 99) < 60); arA = $urandom; arI = $urandom;
      end
      if (!awV || awTaken) begin
        awV = ($urandom_range(0, 99) < 60); awA = $urandom; awI = $urandom;
      end
      hash  = $urandom_range(0, 1) == 1;
      afull = ($urandom_range(0, 99) < 30);
      applyStimulus(arV, arA, arI, awV, awA, awI, hash, afull);
      #2;
      expPush = mHeld && !afull;
      canAcc  = !mHeld || expPush;
      expAr   = canAcc && arV && (!awV || mLastWr);
      expAw   = canAcc && awV && (!arV || !mLastWr);
      nTests++; if (arready_o !== expAr) begin nFail++; $display("[TB] FAIL rnd_arready[%0d] got %0h want %0h", c, arready_o, expAr); end
      nTests++; if (awready_o !== expAw) begin nFail++; $display("[TB] FAIL rnd_awready[%0d] got %0h want %0h", c, awready_o, expAw); end
      nTests++; if (fifo_write_enable_o !== expPush) begin nFail++; $display("[TB] FAIL rnd_push[%0d] got %0h want %0h", c, fifo_write_enable_o, expPush); end
      if (expPush) begin
        nTests++; if (fifo_data_o !== mEntry) begin nFail++; $display("[TB] FAIL rnd_entry[%0d] got %0h want %0h", c, fifo_data_o, mEntry); end
        nTests++; if (slave_o !== mEntry[77:74]) begin nFail++; $display("[TB] FAIL rnd_slave[%0d] got %0h want %0h", c, slave_o, mEntry[77:74]); end
      end
      nTests++; if ({rd_cnt_o, wr_cnt_o, stall_cnt_o} !== {4'(mRd), 4'(mWr), 4'(mSt)}) begin
        nFail++; $display("[TB] FAIL rnd_counters[%0d] got %0h want %0h", c, {rd_cnt_o, wr_cnt_o, stall_cnt_o}, {4'(mRd), 4'(mWr), 4'(mSt)});
      end
      if (mHeld && afull && mSt < CNT_TOP) mSt++;
      if (expAr) begin
        mEntry = modelEntry(arA, arI, 0, hash); mHeld = 1; mLastWr = 0;
        if (mRd < CNT_TOP) mRd++;
      end else if (expAw) begin
        mEntry = modelEntry(awA, awI, 1, hash); mHeld = 1; mLastWr = 1;
        if (mWr < CNT_TOP) mWr++;
      end else if (expPush) begin
        mHeld = 0;
      end
      arTaken = expAr;
      awTaken = expAw;
      @(negedge clk);
    end
  endtask

  // Scenario sequence and the single summary line.
  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_read();
    test_hash();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axi_index_dispatcher.md
Name: axi_index_dispatcher

Overview:
Parametrised successor to the DRAM-cache request index extractor. Accepts AXI read-address (AR) and write-address (AW) requests and arbitrates between them round-robin. It splits each address into offset/index/tag, with optional XOR tag-fold hashing, and selects a target cache slave/bank. It then pushes one packed request entry into the downstream request FIFO through a one-entry output register with almost-full backpressure. It sits between the AXI slave port and the per-bank request FIFO.

Parameters:
ID_W, 32, AXI ID width
ADDR_W, 32, address width
OFFSET_W, 6, line-offset bits (64 B line)
INDEX_W, 10, set-index bits
SLV_W, 4, slave-select width (NUM_SLAVES = 2**SLV_W); SLV_W <= INDEX_W
ENTRY_W, 128, FIFO entry width; must be >= 1+SLV_W+INDEX_W+ID_W+ADDR_W (elaboration error otherwise)
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arid_i  in  ID_W  read request ID
araddr_i  in  ADDR_W  read address
arvalid_i  in  1  read request valid
arready_o  out  1  read request accepted
awid_i  in  ID_W  write request ID
awaddr_i  in  ADDR_W  write address
awvalid_i  in  1  write request valid
awready_o  out  1  write request accepted
hash_en_i  in  1  enable tag-fold index hashing (quasi-static)
fifo_afull_i  in  1  downstream FIFO almost full
fifo_write_enable_o  out  1  push strobe
fifo_data_o  out  ENTRY_W  packed entry
slave_o  out  SLV_W  target slave of the held entry
rd_cnt_o  out  CNT_W  accepted reads
wr_cnt_o  out  CNT_W  accepted writes
stall_cnt_o  out  CNT_W  cycles held entry blocked by fifo_afull_i

Behaviour:
- Reset (async assert, sync deassert by the reset tree): out_valid=0, fifo_data_o=0, slave_o=0, all counters=0, rr_last=WRITE (reads win the first tie). arready_o and awready_o follow from the reset state: 1 if the corresponding valid is high.
- Internal out_valid and entry registers. push = out_valid && !fifo_afull_i. fifo_write_enable_o = push (combinational from the registers and fifo_afull_i).
- can_accept = !out_valid || push, so back-to-back requests sustain one per cycle.
- Grant:
  - Only one valid high -> that channel.
  - Both high -> the channel opposite rr_last.
  - Neither -> none.
  - arready_o = can_accept && grant_rd; awready_o = can_accept && grant_wr. At most one ready per cycle. Readies never depend on the same-cycle readies of other blocks.
- On handshake: load the entry, set out_valid=1, set rr_last to the granted channel. The entry appears the next cycle (latency 1). The push happens in the same cycle if !fifo_afull_i.
- push without a new handshake -> out_valid=0. Entry and slave_o hold their last value while out_valid=0.
- Index arithmetic:
  - idx = addr[OFFSET_W +: INDEX_W].
  - If hash_en_i: idx ^= tag[INDEX_W-1:0], where tag = addr[ADDR_W-1 : OFFSET_W+INDEX_W], zero-extended if narrower than INDEX_W.
  - slave = idx[SLV_W-1:0].
- Entry layout, LSB first: addr[ADDR_W], id[ID_W], idx[INDEX_W], slave[SLV_W], is_write[1]. Remaining upper bits are 0.
- Counters: rd_cnt_o/wr_cnt_o +1 per AR/AW handshake. stall_cnt_o +1 per cycle with out_valid && fifo_afull_i. All saturate at 2**CNT_W-1; no wrap.
- fifo_afull_i held high: the entry holds stable, no readies are asserted, and the AXI valids/payloads stay pending on the master side.
- Reset asserted mid-operation: the held entry is dropped and no push occurs; counters clear.
- hash_en_i is sampled at the handshake cycle only.

Decomposition:
- Shared package dcache_pkg:
  - enum req_type_e {REQ_RD, REQ_WR}
  - packed struct req_entry_t, built from the parameter defaults
  - localparams for the default OFFSET_W/INDEX_W/SLV_W
  - function calc_index(addr, hash_en)
- One natural sub-module: rr_arbiter2, a 2-requester round-robin arbiter with a grant-update enable. The rest stays in the top level.

Test Plan (defaults):
- Read-only: araddr 0x0000_1A40, arid 3, hash off, afull 0 -> arready_o=1 that cycle; next cycle fifo_write_enable_o=1, slave_o=0x9, idx 0x069, is_write 0, id 3; rd_cnt_o=1.
- Hash: awaddr 0x0003_1A40, hash on -> idx 0x06A, slave_o 0xA, is_write 1; wr_cnt_o=1.
- Simultaneous AR and AW held valid for 4 cycles, afull 0 -> grants R,W,R,W; four consecutive pushes with alternating is_write; no cycle with both readies high.
- Backpressure: one request accepted, then fifo_afull_i=1 for 5 cycles -> entry stable, both readies 0 while a new valid is pending, stall_cnt_o=5; afull drops -> push that cycle and the pending request is accepted in the same cycle.
- Reset mid-op: entry held under afull, rst_n pulsed low -> fifo_write_enable_o=0 immediately, counters 0, no push after release.
- Saturation (CNT_W=4): 20 reads accepted -> rd_cnt_o stops at 15.
